freq_meas: RTL and testbench
============================

FREQ_MEAS -- requirements
Module: freq_meas

Interface
REQ-001 SHALL have parameter DIV00, default 50000000: half-period terminal count for code 00.
REQ-002 SHALL have parameter DIV01, default 150000000: half-period terminal count for code 01.
REQ-003 SHALL have parameter DIV10, default 25000000: half-period terminal count for code 10.
REQ-004 SHALL have parameter DIV11, default 175000000: half-period terminal count for code 11.
REQ-005 SHALL have parameter TOL, default 1024: accepted period deviation in clkin cycles (±).
REQ-006 SHALL have port clkin  input  1: sole clock.
REQ-007 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-008 SHALL have port sigin  input  1: divided clock under test, asynchronous to clkin.
REQ-009 SHALL have port aa  output  2: decoded divider code.
REQ-010 SHALL have port locked  output  1: aa is valid.
REQ-011 SHALL have port period  output  32: last measured period in clkin cycles.
REQ-012 SHALL have port lost  output  1: no sigin edge within timeout.

Function
REQ-013 SHALL synchronise sigin through two flops, then detect rising edges on the synchronised value; 1 cycle per edge.
REQ-014 SHALL define the nominal period of code c as 2*(DIVc+1) clkin cycles.
REQ-015 SHALL count clkin cycles between successive rising edges in a 32-bit counter that saturates at 2^32-1.
REQ-016 SHALL use FSM states WAIT_EDGE (no reference edge yet), MEASURE (counting, unlocked), LOCK (counting, locked).
REQ-017 WAIT_EDGE: on edge -> MEASURE, counter cleared to 1.
REQ-018 On each edge in MEASURE/LOCK, SHALL load period with the counter, restart the counter at 1, and classify it as code c if |count - nominal(c)| <= TOL; lowest code wins on overlap.
REQ-019 MEASURE: two consecutive edges classifying to the same code -> LOCK, aa = that code, locked = 1 the cycle after the second edge.
REQ-020 LOCK: edge matching current aa keeps lock; edge matching another code or none -> MEASURE, locked = 0 next cycle, aa holds its last value.
REQ-021 SHALL assert lost and go to WAIT_EDGE when the counter exceeds 2*(DIV11+1)+TOL; lost clears on the next edge.
REQ-022 Edge and timeout in the same cycle: edge wins.

Reset
REQ-023 During rst SHALL force state WAIT_EDGE, counter 0, synchroniser flops 0, aa = 00, locked = 0, period = 0, lost = 0; rst mid-measurement discards the partial count.

Configuration
REQ-024 With FREQ_MEAS_DEGLITCH_EN defined SHALL accept a synchronised sigin level change only after it is stable 3 consecutive clkin cycles (adds 2 cycles of edge latency); without it, edges are used directly.

Structure
REQ-025 SHALL place the FSM state enum and the COUNT_W = 32 constant in a shared package freq_pkg.
REQ-026 SHALL implement the synchroniser, optional deglitcher and edge detector as sub-module edge_sync.

Verification (DIV00=5, DIV01=15, DIV10=2, DIV11=17, TOL=1; nominal periods 12/32/6/36; timeout 37)
REQ-027 sigin period 32, three edges -> period = 32, aa = 01, locked = 1 after the third edge.
REQ-028 Locked at 00 (period 12), switch to period 6 -> locked = 0 on the first 6-cycle edge, aa = 10 and locked = 1 one edge later.
REQ-029 Period 13 -> aa = 00 locked; period 14 -> no match, locked = 0, period = 14.
REQ-030 sigin held low after lock -> lost = 1 at count 38, locked = 0; the next edge clears lost, state MEASURE after the following edge.
REQ-031 rst asserted mid-period while locked -> all outputs zero immediately, relock needs three fresh edges.
REQ-032 With FREQ_MEAS_DEGLITCH_EN, 1- and 2-cycle pulses on sigin -> no edge counted, period unchanged.

Source files
------------

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared FSM state type, counter width and tolerance helper for freq_meas
package freq_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    LOCK      = 2'd2
  } state_t;

  function automatic logic within_tol(input logic [COUNT_W-1:0] cnt,
                                      input logic [COUNT_W-1:0] nom,
                                      input logic [COUNT_W-1:0] tol);
    logic [COUNT_W-1:0] diff;
    diff = (cnt >= nom) ? cnt - nom : nom - cnt;
    return diff <= tol;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchroniser and rising-edge detector for sigin
// FREQ_MEAS_DEGLITCH_EN adds a 3-cycle stability filter ahead of the edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic s1, s2, s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
    end
  end

`ifdef FREQ_MEAS_DEGLITCH_EN
  logic s2_dd, level;

  // level only follows s2 once three consecutive samples agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_d  <= 1'b0;
      s2_dd <= 1'b0;
      level <= 1'b0;
    end else begin
      s2_d  <= s2;
      s2_dd <= s2_d;
      if (s2 == s2_d && s2_d == s2_dd)
        level <= s2;
    end
  end

  assign rise = s2 & s2_d & s2_dd & ~level;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s2_d <= 1'b0;
    else
      s2_d <= s2;
  end

  assign rise = s2 & ~s2_d;
`endif

endmodule

// File: rtl/freq_meas.sv
// rtl/freq_meas.sv - measures sigin period in clkin cycles and locks onto one of four divider codes
// Optional FREQ_MEAS_DEGLITCH_EN enables the input stability filter inside edge_sync.
module freq_meas
  import freq_pkg::*;
#(
  parameter int unsigned DIV00 = 50000000,
  parameter int unsigned DIV01 = 150000000,
  parameter int unsigned DIV10 = 25000000,
  parameter int unsigned DIV11 = 175000000,
  parameter int unsigned TOL   = 1024
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        sigin,
  output logic [1:0]  aa,
  output logic        locked,
  output logic [31:0] period,
  output logic        lost
);

  localparam logic [COUNT_W-1:0] NOM00   = COUNT_W'(2 * (DIV00 + 1));
  localparam logic [COUNT_W-1:0] NOM01   = COUNT_W'(2 * (DIV01 + 1));
  localparam logic [COUNT_W-1:0] NOM10   = COUNT_W'(2 * (DIV10 + 1));
  localparam logic [COUNT_W-1:0] NOM11   = COUNT_W'(2 * (DIV11 + 1));
  localparam logic [COUNT_W-1:0] TOL_V   = COUNT_W'(TOL);
  localparam logic [COUNT_W:0]   TIMEOUT = {1'b0, NOM11} + {1'b0, TOL_V};

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic               rise;
  logic               match;
  logic [1:0]         code;
  logic [1:0]         prev_code;
  logic               prev_valid;
  logic               timeout;

  edge_sync u_sync (
    .clk  (clkin),
    .rst  (rst),
    .sig  (sigin),
    .rise (rise)
  );

  // priority chain: the lowest code wins when tolerance windows overlap
  always_comb begin
    match = 1'b1;
    code  = 2'b00;
    if (within_tol(count, NOM00, TOL_V))
      code = 2'b00;
    else if (within_tol(count, NOM01, TOL_V))
      code = 2'b01;
    else if (within_tol(count, NOM10, TOL_V))
      code = 2'b10;
    else if (within_tol(count, NOM11, TOL_V))
      code = 2'b11;
    else
      match = 1'b0;
  end

  assign timeout = {1'b0, count} > TIMEOUT;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= WAIT_EDGE;
      count      <= '0;
      aa         <= 2'b00;
      locked     <= 1'b0;
      period     <= '0;
      lost       <= 1'b0;
      prev_code  <= 2'b00;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        WAIT_EDGE: begin
          if (rise) begin
            state      <= MEASURE;
            count      <= COUNT_W'(1);
            lost       <= 1'b0;
            prev_valid <= 1'b0;
          end
        end
        MEASURE, LOCK: begin
          // an edge takes precedence over a timeout in the same cycle
          if (rise) begin
            period     <= count;
            count      <= COUNT_W'(1);
            prev_code  <= code;
            prev_valid <= match;
            if (state == LOCK) begin
              if (!match || code != aa) begin
                state  <= MEASURE;
                locked <= 1'b0;
              end
            end else if (match && prev_valid && code == prev_code) begin
              state  <= LOCK;
              aa     <= code;
              locked <= 1'b1;
            end
          end else if (timeout) begin
            state  <= WAIT_EDGE;
            lost   <= 1'b1;
            locked <= 1'b0;
            count  <= '0;
          end else if (count != {COUNT_W{1'b1}}) begin
            count <= count + COUNT_W'(1);
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas.sv
// tb/tb_freq_meas.sv - randomized self-checking bench for freq_meas against a timestamp-based model
module tb_freq_meas;

  localparam int DIV00 = 5;
  localparam int DIV01 = 15;
  localparam int DIV10 = 2;
  localparam int DIV11 = 17;
  localparam int TOL   = 1;
  localparam int LIMIT = 2 * (DIV11 + 1) + TOL;
`ifdef FREQ_MEAS_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic        sigin = 1'b0;
  logic [1:0]  aa;
  logic        locked;
  logic [31:0] period;
  logic        lost;

  freq_meas #(
    .DIV00(DIV00), .DIV01(DIV01), .DIV10(DIV10), .DIV11(DIV11), .TOL(TOL)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .sigin  (sigin),
    .aa     (aa),
    .locked (locked),
    .period (period),
    .lost   (lost)
  );

  always #5 clkin = ~clkin;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rst_at_pos = 1'b1;
  bit sig_at  [0:32767];
  bit filt_at [0:32767];
  int nominal [4] = '{2 * (DIV00 + 1), 2 * (DIV01 + 1), 2 * (DIV10 + 1), 2 * (DIV11 + 1)};

  bit m_wait = 1'b1, m_locked = 1'b0, m_lost = 1'b0;
  int m_aa = 0, m_period = 0, m_last = 0, m_prev = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int classify(input int m);
    for (int c = 0; c < 4; c++)
      if (((m > nominal[c]) ? m - nominal[c] : nominal[c] - m) <= TOL)
        return c;
    return -1;
  endfunction

  // record the level driven in each cycle and its filtered view
  always @(posedge clkin) begin
    cyc = cyc + 1;
    rst_at_pos = rst;
    #2;
    sig_at[cyc] = sigin;
    if (!DEGLITCH)
      filt_at[cyc] = sigin;
    else if (cyc >= 3 && sig_at[cyc] == sig_at[cyc-1] && sig_at[cyc-1] == sig_at[cyc-2])
      filt_at[cyc] = sigin;
    else
      filt_at[cyc] = filt_at[cyc-1];
  end

  // an edge driven in cycle k is acted on by the DUT at clock edge k+3
  always @(negedge clkin) begin
    int p, m, c;
    bit edge_now;
    p = cyc;
    edge_now = (p >= 5) && filt_at[p-3] && !filt_at[p-4];
    if (rst || rst_at_pos) begin
      m_wait = 1'b1; m_locked = 1'b0; m_lost = 1'b0;
      m_aa = 0; m_period = 0; m_prev = -1;
    end else if (edge_now) begin
      if (m_wait) begin
        m_wait = 1'b0; m_lost = 1'b0; m_prev = -1;
      end else begin
        m = p - m_last;
        c = classify(m);
        m_period = m;
        if (m_locked) begin
          if (c != m_aa) m_locked = 1'b0;
        end else if (c >= 0 && c == m_prev) begin
          m_locked = 1'b1;
          m_aa = c;
        end
        m_prev = c;
      end
      m_last = p;
    end else if (!m_wait && p - m_last > LIMIT) begin
      m_lost = 1'b1; m_locked = 1'b0; m_wait = 1'b1;
    end
    chk("aa", 32'(aa), 32'(m_aa));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("period", period, 32'(m_period));
    chk("lost", 32'(lost), 32'(m_lost));
  end

  task automatic drive(input bit v);
    @(posedge clkin);
    #1 sigin = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic square(input int per, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++) drive(i < per / 2);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clkin);
    #1 sigin = 1'b0;
    rst = 1'b1;
    repeat (hold) @(posedge clkin);
    #1 rst = 1'b0;
    idle(6);
  endtask

  initial begin
    int r, per, n;
    repeat (3) @(posedge clkin);
    #1;
    chk("reset_aa", 32'(aa), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_period", period, 0);
    chk("reset_lost", 32'(lost), 0);
    rst = 1'b0;
    idle(6);

    square(32, 3);
    @(negedge clkin);
    chk("lock01_period", period, 32);
    chk("lock01_aa", 32'(aa), 1);
    chk("lock01_locked", 32'(locked), 1);

    square(12, 4);
    square(6, 2);
    @(negedge clkin);
    chk("switch_unlock", 32'(locked), 0);
    chk("switch_aa_hold", 32'(aa), 0);
    chk("switch_period", period, 6);
    square(6, 1);
    @(negedge clkin);
    chk("relock10_aa", 32'(aa), 2);
    chk("relock10_locked", 32'(locked), 1);

    square(13, 3);
    @(negedge clkin);
    chk("tol13_aa", 32'(aa), 0);
    chk("tol13_locked", 32'(locked), 1);
    square(14, 2);
    @(negedge clkin);
    chk("nomatch14_locked", 32'(locked), 0);
    chk("nomatch14_period", period, 14);

    square(12, 3);
    idle(45);
    @(negedge clkin);
    chk("timeout_lost", 32'(lost), 1);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_aa", 32'(aa), 0);
    square(12, 1);
    @(negedge clkin);
    chk("lost_clear", 32'(lost), 0);
    square(12, 2);
    @(negedge clkin);
    chk("relock_after_lost", 32'(locked), 1);

    drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b0); drive(1'b0);
    @(posedge clkin);
    #1 sigin = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_aa", 32'(aa), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_period", period, 0);
    chk("midrst_lost", 32'(lost), 0);
    repeat (5) @(posedge clkin);
    #1 rst = 1'b0;
    idle(6);
    square(32, 2);
    @(negedge clkin);
    chk("after_rst_two_edges", 32'(locked), 0);
    square(32, 1);
    @(negedge clkin);
    chk("after_rst_three_edges", 32'(locked), 1);
    chk("after_rst_aa", 32'(aa), 1);

`ifdef FREQ_MEAS_DEGLITCH_EN
    square(12, 3);
    drive(1'b1); idle(4);
    drive(1'b1); drive(1'b1); idle(4);
    @(negedge clkin);
    chk("glitch_period", period, 12);
    chk("glitch_locked", 32'(locked), 1);
`endif

    for (int s = 0; s < 50; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_reset(5);
      end else if (r == 1) begin
        idle($urandom_range(20, 50));
      end else if (r == 2) begin
        n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) begin
          for (int h = 0; h < $urandom_range(1, 2); h++) drive(1'b1);
          idle($urandom_range(3, 5));
        end
      end else begin
        if ($urandom_range(0, 1) == 1)
          per = nominal[$urandom_range(0, 3)] + $urandom_range(0, 4) - 2;
        else
          per = $urandom_range(6, 45);
        square(per, $urandom_range(1, 4));
      end
    end

    idle(4);
    @(negedge clkin);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
